// File: rtl/apb_isqrt_slave_if.sv
// ---------------------------------------------------------------------------
// apb_isqrt_slave_if
//   APB bus bundle between a requester and the isqrt completer.
//
//   PSEL     select                (master -> slave)
//   PENABLE  access phase          (master -> slave)
//   PWRITE   1=write, 0=read       (master -> slave)
//   PADDR    byte address          (master -> slave)
//   PWDATA   write data            (master -> slave)
//   PRDATA   read data             (slave -> master)
//   PREADY   transfer complete     (slave -> master)
//   PSLVERR  error response        (slave -> master)
// ---------------------------------------------------------------------------
interface apb_isqrt_slave_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_isqrt_slave.sv
// ---------------------------------------------------------------------------
// apb_isqrt_slave
//   APB completer computing a 32-bit unsigned integer square root, one root
//   bit per PCLK (restoring digit-by-digit method, 16 iterations).
//
//   Ports:
//     PCLK    bus clock, all state on the rising edge
//     PRESET  asynchronous active-low reset
//     bus     APB slave modport (PSEL/PENABLE/PWRITE/PADDR/PWDATA in,
//             PRDATA/PREADY/PSLVERR out)
//     irq     level interrupt = DONE & IRQ_EN
//
//   Register map (PADDR[4:2]):
//     0x00 OPERAND  RW (write while busy -> PSLVERR, ignored)
//     0x04 CTRL     [0] START (W1 pulse, reads 0)  [1] IRQ_EN
//     0x08 STATUS   [0] BUSY (RO)  [1] DONE (W1C, sticky)
//     0x0C ROOT     RO [15:0]
//     0x10 REM      RO [16:0]
//     0x14-0x1C     unmapped: PSLVERR, reads 0
//
//   Compute FSM:
//     state   | meaning
//     --------+---------------------------------------------------------
//     ST_IDLE | no computation; BUSY=0, result registers hold last result
//     ST_CALC | iterating; BUSY=1, reads of ROOT/REM are stalled
// ---------------------------------------------------------------------------
module apb_isqrt_slave #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                PCLK,
   input  logic                PRESET,
   apb_isqrt_slave_if.slave    bus,
   output logic                irq
);

   localparam int ROOT_W = DATA_W / 2;
   localparam int REM_W  = ROOT_W + 1;
   localparam int STEP_W = REM_W + 2;
   localparam int CNT_W  = $clog2(ROOT_W);

   localparam logic [2:0] A_OP   = 3'd0;
   localparam logic [2:0] A_CTRL = 3'd1;
   localparam logic [2:0] A_STAT = 3'd2;
   localparam logic [2:0] A_ROOT = 3'd3;
   localparam logic [2:0] A_REM  = 3'd4;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_W - 1);

   typedef enum logic {
      ST_IDLE,
      ST_CALC
   } state_t;

   state_t              state_q,  state_d;
   logic [DATA_W-1:0]   op_q,     op_d;
   logic [DATA_W-1:0]   work_q,   work_d;
   logic [ROOT_W-1:0]   wroot_q,  wroot_d;
   logic [REM_W-1:0]    wrem_q,   wrem_d;
   logic [CNT_W-1:0]    cnt_q,    cnt_d;
   logic [ROOT_W-1:0]   root_q,   root_d;
   logic [REM_W-1:0]    rem_q,    rem_d;
   logic                irq_en_q, irq_en_d;
   logic                done_q,   done_d;

   logic                busy;
   logic [2:0]          reg_idx;
   logic                access;
   logic                rd_result;
   logic                pready;
   logic                wr_fire;
   logic                slverr;
   logic [DATA_W-1:0]   rdata;

   logic [STEP_W-1:0]   rem_sh;
   logic [STEP_W-1:0]   trial;
   logic                take;
   logic [STEP_W-1:0]   rem_nxt;
   logic [ROOT_W-1:0]   root_nxt;

   logic                unused_bits;

   assign busy      = (state_q == ST_CALC);
   assign reg_idx   = bus.PADDR[4:2];
   assign access    = bus.PSEL & bus.PENABLE;
   assign rd_result = (reg_idx == A_ROOT) || (reg_idx == A_REM);

   // Only result reads wait for the iteration; every other access,
   // including writes during a computation, completes at once.
   assign pready  = ~(access & ~bus.PWRITE & rd_result & busy);
   assign wr_fire = access & bus.PWRITE & pready;

   always_comb begin
      slverr = 1'b0;
      case (reg_idx)
         A_OP:           slverr = bus.PWRITE & busy;
         A_CTRL:         slverr = bus.PWRITE & bus.PWDATA[0] & busy;
         A_STAT:         slverr = 1'b0;
         A_ROOT, A_REM:  slverr = bus.PWRITE;
         default:        slverr = 1'b1;
      endcase
   end

   always_comb begin
      rdata = '0;
      case (reg_idx)
         A_OP:    rdata = op_q;
         A_CTRL:  rdata = {{(DATA_W-2){1'b0}}, irq_en_q, 1'b0};
         A_STAT:  rdata = {{(DATA_W-2){1'b0}}, done_q, busy};
         A_ROOT:  rdata = {{(DATA_W-ROOT_W){1'b0}}, root_q};
         A_REM:   rdata = {{(DATA_W-REM_W){1'b0}}, rem_q};
         default: rdata = '0;
      endcase
   end

   assign bus.PREADY  = pready;
   assign bus.PSLVERR = access & pready & slverr;
   assign bus.PRDATA  = (access & pready) ? rdata : '0;

   assign irq = done_q & irq_en_q;

   // One restoring iteration: bring down the next two operand bits and try
   // to subtract (root << 2) | 1.  The partial remainder never exceeds
   // 2*root, so REM_W bits hold the kept value.
   assign rem_sh   = {wrem_q, work_q[DATA_W-1 -: 2]};
   assign trial    = {1'b0, wroot_q, 2'b01};
   assign take     = (rem_sh >= trial);
   assign rem_nxt  = take ? (rem_sh - trial) : rem_sh;
   assign root_nxt = {wroot_q[ROOT_W-2:0], take};

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      work_d   = work_q;
      wroot_d  = wroot_q;
      wrem_d   = wrem_q;
      cnt_d    = cnt_q;
      root_d   = root_q;
      rem_d    = rem_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;

      if (wr_fire) begin
         case (reg_idx)
            A_OP: begin
               if (!busy) op_d = bus.PWDATA;
            end
            A_CTRL: begin
               irq_en_d = bus.PWDATA[1];
               if (bus.PWDATA[0] && !busy) begin
                  state_d = ST_CALC;
                  done_d  = 1'b0;
                  work_d  = op_q;
                  wroot_d = '0;
                  wrem_d  = '0;
                  cnt_d   = '0;
               end
            end
            A_STAT: begin
               if (bus.PWDATA[1]) done_d = 1'b0;
            end
            default: ;
         endcase
      end

      // Evaluated after the bus writes so a DONE set beats a same-edge clear.
      if (state_q == ST_CALC) begin
         work_d  = {work_q[DATA_W-3:0], 2'b00};
         wroot_d = root_nxt;
         wrem_d  = rem_nxt[REM_W-1:0];
         cnt_d   = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            root_d  = root_nxt;
            rem_d   = rem_nxt[REM_W-1:0];
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         work_q   <= '0;
         wroot_q  <= '0;
         wrem_q   <= '0;
         cnt_q    <= '0;
         root_q   <= '0;
         rem_q    <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         work_q   <= work_d;
         wroot_q  <= wroot_d;
         wrem_q   <= wrem_d;
         cnt_q    <= cnt_d;
         root_q   <= root_d;
         rem_q    <= rem_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
      end
   end

   assign unused_bits = ^{bus.PADDR[ADDR_W-1:5], bus.PADDR[1:0], rem_nxt[STEP_W-1:REM_W]};

endmodule

// File: tb/tb_apb_isqrt_slave.sv
module tb_apb_isqrt_slave;

   logic PCLK;
   logic PRESET;
   logic irq;

   apb_isqrt_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_isqrt_slave #(.ADDR_W(32), .DATA_W(32)) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .bus    (bus.slave),
      .irq    (irq)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
      bit          chk_data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   last_stalls;

   // Monitor: pops one expectation per completed transfer.
   always @(negedge PCLK) begin
      if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_completion addr=%h actual data=%h err=%b required none",
                     bus.PADDR, bus.PRDATA, bus.PSLVERR);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.PSLVERR !== mon_e.err || (mon_e.chk_data && bus.PRDATA !== mon_e.data)) begin
               failures++;
               $display("FAIL apb_xfer addr=%h actual data=%h err=%b required data=%h err=%b",
                        mon_e.addr, bus.PRDATA, bus.PSLVERR, mon_e.data, mon_e.err);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Starts right away (back-to-back legal) and returns 1ns after the
   // completing edge.
   task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_d, input logic exp_err);
      exp_t e;
      int   stalls;
      e.addr = addr; e.data = exp_d; e.err = exp_err; e.chk_data = !wr;
      exp_q.push_back(e);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
      bus.PADDR = addr; bus.PWDATA = wdata;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      stalls = 0;
      @(negedge PCLK);
      while (!bus.PREADY && stalls < 200) begin
         stalls++;
         @(negedge PCLK);
      end
      if (!bus.PREADY) begin
         checks++;
         failures++;
         $display("FAIL pready_timeout addr=%h actual stalls=%0d required completion", addr, stalls);
      end
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      last_stalls = stalls;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic err);
      apb(1'b1, addr, d, 32'h0, err);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d, input logic err);
      apb(1'b0, addr, 32'h0, exp_d, err);
   endtask

   task automatic run_sqrt(input logic [31:0] op, input logic [31:0] root, input logic [31:0] rem);
      wr(32'h00, op, 1'b0);
      wr(32'h04, 32'h1, 1'b0);
      rd(32'h0C, root, 1'b0);
      rd(32'h10, rem, 1'b0);
   endtask

   initial begin
      PRESET = 1'b0;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = '0; bus.PWDATA = '0;
      #12;
      chk("reset_pready", {31'b0, bus.PREADY}, 32'h1);
      chk("reset_pslverr", {31'b0, bus.PSLVERR}, 32'h0);
      chk("reset_prdata", bus.PRDATA, 32'h0);
      chk("reset_irq", {31'b0, irq}, 32'h0);
      @(posedge PCLK); #1 PRESET = 1'b1;
      @(posedge PCLK); #1;

      for (int a = 0; a < 5; a++) rd(32'(a * 4), 32'h0, 1'b0);

      // 17 -> 4 rem 1; BUSY visible across the 8 polls that land before
      // the 16th iteration edge, DONE on the 9th.
      wr(32'h00, 32'd17, 1'b0);
      wr(32'h04, 32'h1, 1'b0);
      for (int k = 0; k < 8; k++) rd(32'h08, 32'h1, 1'b0);
      rd(32'h08, 32'h2, 1'b0);
      rd(32'h0C, 32'd4, 1'b0);
      rd(32'h10, 32'd1, 1'b0);
      rd(32'h00, 32'd17, 1'b0);

      // Largest operand; immediate ROOT read stalls 15 sampled cycles.
      wr(32'h00, 32'hFFFF_FFFF, 1'b0);
      wr(32'h04, 32'h1, 1'b0);
      rd(32'h0C, 32'h0000_FFFF, 1'b0);
      chk("stall_cycles", 32'(last_stalls), 32'd15);
      rd(32'h10, 32'h0001_FFFE, 1'b0);

      run_sqrt(32'd0, 32'd0, 32'd0);
      run_sqrt(32'd1, 32'd1, 32'd0);
      run_sqrt(32'd99, 32'd9, 32'd18);

      // Interrupt path and error responses while busy.
      wr(32'h04, 32'h2, 1'b0);
      rd(32'h04, 32'h2, 1'b0);
      wr(32'h00, 32'd144, 1'b0);
      wr(32'h04, 32'h3, 1'b0);
      chk("irq_while_busy", {31'b0, irq}, 32'h0);
      wr(32'h04, 32'h3, 1'b1);
      wr(32'h00, 32'd5, 1'b1);
      wr(32'h18, 32'h1, 1'b1);
      rd(32'h18, 32'h0, 1'b1);
      wr(32'h0C, 32'h7, 1'b1);
      rd(32'h0C, 32'd12, 1'b0);
      chk("irq_on_done", {31'b0, irq}, 32'h1);
      rd(32'h08, 32'h2, 1'b0);
      rd(32'h00, 32'd144, 1'b0);
      wr(32'h08, 32'h2, 1'b0);
      chk("irq_after_clear", {31'b0, irq}, 32'h0);
      rd(32'h08, 32'h0, 1'b0);

      // START while busy with IRQ_EN=0 still updates IRQ_EN.
      wr(32'h04, 32'h3, 1'b0);
      wr(32'h04, 32'h1, 1'b1);
      rd(32'h0C, 32'd12, 1'b0);
      chk("irq_en_updated_while_busy", {31'b0, irq}, 32'h0);
      rd(32'h04, 32'h0, 1'b0);
      rd(32'h08, 32'h2, 1'b0);

      // Read abandoned mid-stall: no effect, later read sees the result.
      wr(32'h00, 32'd1000000, 1'b0);
      wr(32'h04, 32'h1, 1'b0);
      bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 32'h0C;
      @(posedge PCLK); #1 bus.PENABLE = 1'b1;
      repeat (3) @(posedge PCLK);
      #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      rd(32'h0C, 32'd1000, 1'b0);
      rd(32'h10, 32'd0, 1'b0);

      // Reset during the 8th iteration edge, with a stalled ROOT read open.
      wr(32'h04, 32'h2, 1'b0);
      wr(32'h00, 32'd99, 1'b0);
      wr(32'h04, 32'h3, 1'b0);
      bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 32'h0C;
      @(posedge PCLK); #1 bus.PENABLE = 1'b1;
      repeat (7) @(posedge PCLK);
      exp_q.push_back('{addr: 32'h0C, data: 32'h0, err: 1'b0, chk_data: 1'b1});
      #2 PRESET = 1'b0;
      #1;
      chk("midcalc_reset_pready", {31'b0, bus.PREADY}, 32'h1);
      chk("midcalc_reset_prdata", bus.PRDATA, 32'h0);
      chk("midcalc_reset_irq", {31'b0, irq}, 32'h0);
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      PRESET = 1'b1;
      repeat (20) @(posedge PCLK);
      #1;
      chk("post_reset_irq", {31'b0, irq}, 32'h0);
      rd(32'h08, 32'h0, 1'b0);
      rd(32'h0C, 32'h0, 1'b0);
      run_sqrt(32'd99, 32'd9, 32'd18);
      rd(32'h08, 32'h2, 1'b0);

      repeat (2) @(posedge PCLK);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
